// File: rtl/fios_casc_4a_ctrl.sv
// Sequencer for a cascaded-DSP FIOS Montgomery PE chain: per outer word it loads
// a, then steps the AB, M and MP phases, then drains the cascade before reporting done.
module fios_casc_4a_ctrl #(
  parameter int          S            = 4,
  parameter int          ABREG        = 1,
  parameter int          MREG         = 1,
  parameter int          FLUSH_CYCLES = 8,
  parameter logic [8:0]  OPMODE_AB    = 9'h035,
  parameter logic [8:0]  OPMODE_M     = 9'h005,
  parameter logic [8:0]  OPMODE_MP    = 9'h095
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       a_reg_en_o,
  output logic       m_reg_en_o,
  output logic       CREG_en_o,
  output logic       RES_delay_en_o,
  output logic [1:0] mux_A_sel_o,
  output logic [1:0] mux_B_sel_o,
  output logic [1:0] mux_C_sel_o,
  output logic [8:0] OPMODE_o,
  output logic [5:0] word_idx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int DSP_REG_LEVEL = 1 + ABREG + MREG;
  localparam int FD            = (DSP_REG_LEVEL == 3) ? 4 : DSP_REG_LEVEL;

  localparam logic [3:0] FD_P       = 4'(FD);
  localparam logic [3:0] FD2_P      = 4'(2 * FD);
  localparam logic [3:0] PH_M_LAST  = 4'(2 * FD - 1);
  localparam logic [3:0] PH_LAST    = 4'(3 * FD - 1);
  localparam logic [5:0] I_LAST     = 6'(S - 1);
  localparam logic [7:0] FL_LAST    = 8'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ph_q, ph_d;
  logic [5:0] i_q, i_d;
  logic [7:0] fl_q, fl_d;

  logic       a_reg_en_q, a_reg_en_d;
  logic       m_reg_en_q, m_reg_en_d;
  logic       creg_en_q, creg_en_d;
  logic       res_delay_en_q, res_delay_en_d;
  logic [1:0] mux_a_q, mux_a_d;
  logic [1:0] mux_b_q, mux_b_d;
  logic [1:0] mux_c_q, mux_c_d;
  logic [8:0] opmode_q, opmode_d;
  logic [5:0] word_idx_q, word_idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    i_d     = i_q;
    fl_d    = fl_q;
    if (abort_i) begin
      state_d = IDLE;
      ph_d    = '0;
      i_d     = '0;
      fl_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = LOAD;
            ph_d    = '0;
            i_d     = '0;
            fl_d    = '0;
          end
        end
        LOAD: begin
          state_d = RUN;
          ph_d    = '0;
        end
        RUN: begin
          if (ph_q == PH_LAST) begin
            ph_d = '0;
            if (i_q < I_LAST) begin
              state_d = LOAD;
              i_d     = i_q + 6'd1;
            end else begin
              state_d = FLUSH;
              fl_d    = '0;
            end
          end else begin
            ph_d = ph_q + 4'd1;
          end
        end
        FLUSH: begin
          if (fl_q == FL_LAST) begin
            state_d = DONE;
          end else begin
            fl_d = fl_q + 8'd1;
          end
        end
        DONE: begin
          state_d = IDLE;
          ph_d    = '0;
          i_d     = '0;
          fl_d    = '0;
        end
        default: begin
          state_d = IDLE;
          ph_d    = '0;
          i_d     = '0;
          fl_d    = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with the state they describe.
  always_comb begin
    a_reg_en_d     = 1'b0;
    m_reg_en_d     = 1'b0;
    creg_en_d      = 1'b0;
    res_delay_en_d = 1'b0;
    mux_a_d        = 2'd3;
    mux_b_d        = 2'd3;
    mux_c_d        = 2'd3;
    opmode_d       = '0;
    word_idx_d     = '0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    case (state_d)
      LOAD: begin
        busy_d     = 1'b1;
        a_reg_en_d = 1'b1;
        word_idx_d = i_d;
      end
      RUN: begin
        busy_d     = 1'b1;
        word_idx_d = i_d;
        if (ph_d < FD_P) begin
          mux_a_d  = 2'd0;
          mux_b_d  = 2'd0;
          mux_c_d  = (i_d == 6'd0) ? 2'd0 : 2'd1;
          opmode_d = OPMODE_AB;
        end else if (ph_d < FD2_P) begin
          mux_a_d    = 2'd1;
          mux_b_d    = 2'd1;
          mux_c_d    = 2'd1;
          opmode_d   = OPMODE_M;
          m_reg_en_d = (ph_d == PH_M_LAST);
        end else begin
          mux_a_d        = 2'd2;
          mux_b_d        = 2'd2;
          mux_c_d        = 2'd1;
          creg_en_d      = 1'b1;
          opmode_d       = OPMODE_MP;
          res_delay_en_d = (ph_d == PH_LAST);
        end
      end
      FLUSH: begin
        busy_d     = 1'b1;
        mux_a_d    = 2'd2;
        mux_b_d    = 2'd2;
        mux_c_d    = 2'd1;
        opmode_d   = OPMODE_MP;
        word_idx_d = i_d;
      end
      DONE: begin
        done_d     = 1'b1;
        word_idx_d = i_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= IDLE;
      ph_q           <= '0;
      i_q            <= '0;
      fl_q           <= '0;
      a_reg_en_q     <= 1'b0;
      m_reg_en_q     <= 1'b0;
      creg_en_q      <= 1'b0;
      res_delay_en_q <= 1'b0;
      mux_a_q        <= 2'd3;
      mux_b_q        <= 2'd3;
      mux_c_q        <= 2'd3;
      opmode_q       <= '0;
      word_idx_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ph_q           <= ph_d;
      i_q            <= i_d;
      fl_q           <= fl_d;
      a_reg_en_q     <= a_reg_en_d;
      m_reg_en_q     <= m_reg_en_d;
      creg_en_q      <= creg_en_d;
      res_delay_en_q <= res_delay_en_d;
      mux_a_q        <= mux_a_d;
      mux_b_q        <= mux_b_d;
      mux_c_q        <= mux_c_d;
      opmode_q       <= opmode_d;
      word_idx_q     <= word_idx_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign a_reg_en_o     = a_reg_en_q;
  assign m_reg_en_o     = m_reg_en_q;
  assign CREG_en_o      = creg_en_q;
  assign RES_delay_en_o = res_delay_en_q;
  assign mux_A_sel_o    = mux_a_q;
  assign mux_B_sel_o    = mux_b_q;
  assign mux_C_sel_o    = mux_c_q;
  assign OPMODE_o       = opmode_q;
  assign word_idx_o     = word_idx_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_fios_casc_4a_ctrl.sv
// Randomized bench for fios_casc_4a_ctrl: two instances (FD=4 and FD=1) compared cycle by
// cycle against a model derived from the cycle offset since start acceptance.
module tb_fios_casc_4a_ctrl;

  localparam logic [8:0] OP_AB = 9'h035;
  localparam logic [8:0] OP_M  = 9'h005;
  localparam logic [8:0] OP_MP = 9'h095;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       a_en;
    logic       m_en;
    logic       c_en;
    logic       r_en;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] sc;
    logic [8:0] op;
    logic [5:0] wi;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, start_a, abort_a;
  logic a_busy, a_done, a_aen, a_men, a_cen, a_ren;
  logic [1:0] a_sa, a_sb, a_sc;
  logic [8:0] a_op;
  logic [5:0] a_wi;

  logic rst_b, start_b, abort_b;
  logic b_busy, b_done, b_aen, b_men, b_cen, b_ren;
  logic [1:0] b_sa, b_sb, b_sc;
  logic [8:0] b_op;
  logic [5:0] b_wi;

  outs_t obs_a, obs_b;
  assign obs_a = {a_busy, a_done, a_aen, a_men, a_cen, a_ren, a_sa, a_sb, a_sc, a_op, a_wi};
  assign obs_b = {b_busy, b_done, b_aen, b_men, b_cen, b_ren, b_sa, b_sb, b_sc, b_op, b_wi};

  int n_checks = 0;
  int n_pass   = 0;

  fios_casc_4a_ctrl #(.S(4), .ABREG(1), .MREG(1), .FLUSH_CYCLES(8)) dut_a (
    .clock_i(clk), .reset_i(rst_a), .start_i(start_a), .abort_i(abort_a),
    .a_reg_en_o(a_aen), .m_reg_en_o(a_men), .CREG_en_o(a_cen), .RES_delay_en_o(a_ren),
    .mux_A_sel_o(a_sa), .mux_B_sel_o(a_sb), .mux_C_sel_o(a_sc), .OPMODE_o(a_op),
    .word_idx_o(a_wi), .busy_o(a_busy), .done_o(a_done)
  );

  fios_casc_4a_ctrl #(.S(2), .ABREG(0), .MREG(0), .FLUSH_CYCLES(3)) dut_b (
    .clock_i(clk), .reset_i(rst_b), .start_i(start_b), .abort_i(abort_b),
    .a_reg_en_o(b_aen), .m_reg_en_o(b_men), .CREG_en_o(b_cen), .RES_delay_en_o(b_ren),
    .mux_A_sel_o(b_sa), .mux_B_sel_o(b_sb), .mux_C_sel_o(b_sc), .OPMODE_o(b_op),
    .word_idx_o(b_wi), .busy_o(b_busy), .done_o(b_done)
  );

  // Expected outputs k cycles after the accept edge (k=0 or past done means idle); m masks don't-care fields.
  function automatic void model(input int k, input int s, input int fd, input int fl,
                                output outs_t e, output outs_t m);
    int iter, run_len, it, r, ph;
    iter    = 1 + 3 * fd;
    run_len = s * iter;
    e    = '0;
    e.sa = 2'd3;
    e.sb = 2'd3;
    e.sc = 2'd3;
    m    = '1;
    if (k >= 1 && k <= run_len) begin
      it     = (k - 1) / iter;
      r      = (k - 1) % iter;
      e.busy = 1'b1;
      e.wi   = 6'(it);
      if (r == 0) begin
        e.a_en = 1'b1;
      end else begin
        ph = r - 1;
        if (ph < fd) begin
          e.sa = 2'd0; e.sb = 2'd0; e.sc = (it == 0) ? 2'd0 : 2'd1; e.op = OP_AB;
        end else if (ph < 2 * fd) begin
          e.sa = 2'd1; e.sb = 2'd1; e.op = OP_M; e.m_en = (ph == 2 * fd - 1); m.sc = '0;
        end else begin
          e.sa = 2'd2; e.sb = 2'd2; e.sc = 2'd1; e.c_en = 1'b1; e.op = OP_MP;
          e.r_en = (ph == 3 * fd - 1);
        end
      end
    end else if (k > run_len && k <= run_len + fl) begin
      e.busy = 1'b1; e.op = OP_MP; e.wi = 6'(s - 1);
      m.sa = '0; m.sb = '0; m.sc = '0;
    end else if (k == run_len + fl + 1) begin
      e.done = 1'b1;
      m.sa = '0; m.sb = '0; m.sc = '0; m.op = '0; m.wi = '0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    outs_t e, m;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    model(0, 4, 4, 8, e, m);
    n_checks++;
    if (obs_a !== e) $display("[TB] FAIL reset_a got=%h want=%h", obs_a, e);
    else n_pass++;
    n_checks++;
    if (obs_b !== e) $display("[TB] FAIL reset_b got=%h want=%h", obs_b, e);
    else n_pass++;
    tick();
    tick();
    rst_a = 1'b1; rst_b = 1'b1;
    tick();
    n_checks++;
    if (obs_a !== e) $display("[TB] FAIL post_reset_a got=%h want=%h", obs_a, e);
    else n_pass++;
    n_checks++;
    if (obs_b !== e) $display("[TB] FAIL post_reset_b got=%h want=%h", obs_b, e);
    else n_pass++;
  endtask

  task automatic test_abort_vs_start();
    outs_t e, m;
    model(0, 4, 4, 8, e, m);
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    n_checks++;
    if (obs_a !== e) $display("[TB] FAIL abort_wins got=%h want=%h", obs_a, e);
    else n_pass++;
    tick();
    n_checks++;
    if (obs_a !== e) $display("[TB] FAIL abort_wins_hold got=%h want=%h", obs_a, e);
    else n_pass++;
  endtask

  task automatic test_full_run_a();
    outs_t e, m;
    int gap, busy_cnt, m_cnt, done_k;
    gap = int'($urandom_range(0, 5));
    for (int g = 0; g < gap; g++) begin
      tick();
      model(0, 4, 4, 8, e, m);
      n_checks++;
      if (obs_a !== e) $display("[TB] FAIL idle_gap got=%h want=%h", obs_a, e);
      else n_pass++;
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    busy_cnt = 0; m_cnt = 0; done_k = -1;
    for (int k = 1; k <= 63; k++) begin
      model(k, 4, 4, 8, e, m);
      n_checks++;
      if ((obs_a & m) !== (e & m)) $display("[TB] FAIL run_a k=%0d got=%h want=%h", k, obs_a & m, e & m);
      else n_pass++;
      if (a_busy) busy_cnt++;
      if (a_men) m_cnt++;
      if (a_done && done_k < 0) done_k = k;
      tick();
    end
    n_checks++;
    if (busy_cnt !== 60) $display("[TB] FAIL busy_cycles got=%0d want=60", busy_cnt);
    else n_pass++;
    n_checks++;
    if (m_cnt !== 4) $display("[TB] FAIL m_pulses got=%0d want=4", m_cnt);
    else n_pass++;
    n_checks++;
    if (done_k !== 61) $display("[TB] FAIL done_cycle got=%0d want=61", done_k);
    else n_pass++;
  endtask

  task automatic test_fd1_run_b();
    outs_t e, m;
    int gap;
    gap = int'($urandom_range(0, 3));
    for (int g = 0; g < gap; g++) tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      model(k, 2, 1, 3, e, m);
      n_checks++;
      if ((obs_b & m) !== (e & m)) $display("[TB] FAIL run_b k=%0d got=%h want=%h", k, obs_b & m, e & m);
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if (b_sc !== 2'd0) $display("[TB] FAIL first_ab_c got=%0d want=0", b_sc);
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if (b_sc !== 2'd1) $display("[TB] FAIL second_ab_c got=%0d want=1", b_sc);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_start_held();
    outs_t e, m;
    int done_cnt;
    done_cnt = 0;
    start_a = 1'b1;
    tick();
    for (int k = 1; k <= 63; k++) begin
      model((k == 63) ? 1 : k, 4, 4, 8, e, m);
      n_checks++;
      if ((obs_a & m) !== (e & m)) $display("[TB] FAIL held_start k=%0d got=%h want=%h", k, obs_a & m, e & m);
      else n_pass++;
      if (a_done) done_cnt++;
      if (k < 63) tick();
    end
    n_checks++;
    if (done_cnt !== 1) $display("[TB] FAIL held_done_count got=%0d want=1", done_cnt);
    else n_pass++;
    start_a = 1'b0; abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    model(0, 4, 4, 8, e, m);
    n_checks++;
    if (obs_a !== e) $display("[TB] FAIL held_cleanup got=%h want=%h", obs_a, e);
    else n_pass++;
  endtask

  task automatic test_abort_mid_run();
    outs_t e, m;
    logic saw_busy, saw_done;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      model(k, 4, 4, 8, e, m);
      n_checks++;
      if ((obs_a & m) !== (e & m)) $display("[TB] FAIL pre_abort k=%0d got=%h want=%h", k, obs_a & m, e & m);
      else n_pass++;
      if (k < 17) tick();
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    model(0, 4, 4, 8, e, m);
    n_checks++;
    if (obs_a !== e) $display("[TB] FAIL abort_idle got=%h want=%h", obs_a, e);
    else n_pass++;
    saw_busy = 1'b0; saw_done = 1'b0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (a_busy) saw_busy = 1'b1;
      if (a_done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("[TB] FAIL abort_no_done got=%b want=0", saw_done);
    else n_pass++;
    n_checks++;
    if (saw_busy !== 1'b0) $display("[TB] FAIL abort_no_busy got=%b want=0", saw_busy);
    else n_pass++;
  endtask

  task automatic test_random_abort();
    outs_t e, m;
    int ka;
    for (int rep = 0; rep < 3; rep++) begin
      ka = int'($urandom_range(1, 61));
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int k = 1; k <= ka; k++) begin
        model(k, 4, 4, 8, e, m);
        n_checks++;
        if ((obs_a & m) !== (e & m)) $display("[TB] FAIL rnd_run k=%0d got=%h want=%h", k, obs_a & m, e & m);
        else n_pass++;
        if (k < ka) tick();
      end
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      model(0, 4, 4, 8, e, m);
      n_checks++;
      if (obs_a !== e) $display("[TB] FAIL rnd_abort ka=%0d got=%h want=%h", ka, obs_a, e);
      else n_pass++;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        model(k, 4, 4, 8, e, m);
        n_checks++;
        if ((obs_a & m) !== (e & m)) $display("[TB] FAIL rnd_restart k=%0d got=%h want=%h", k, obs_a & m, e & m);
        else n_pass++;
        tick();
      end
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
    end
  endtask

  task automatic test_reset_flush();
    outs_t e, m;
    logic saw_busy, saw_done;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k < 55; k++) tick();
    model(55, 4, 4, 8, e, m);
    n_checks++;
    if ((obs_a & m) !== (e & m)) $display("[TB] FAIL in_flush got=%h want=%h", obs_a & m, e & m);
    else n_pass++;
    rst_a = 1'b0;
    #1;
    model(0, 4, 4, 8, e, m);
    n_checks++;
    if (obs_a !== e) $display("[TB] FAIL async_reset got=%h want=%h", obs_a, e);
    else n_pass++;
    #2;
    rst_a = 1'b1;
    saw_busy = 1'b0; saw_done = 1'b0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (a_busy) saw_busy = 1'b1;
      if (a_done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("[TB] FAIL reset_no_done got=%b want=0", saw_done);
    else n_pass++;
    n_checks++;
    if (saw_busy !== 1'b0) $display("[TB] FAIL reset_no_resume got=%b want=0", saw_busy);
    else n_pass++;
  endtask

  task automatic test_start_in_done();
    outs_t e, m;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k < 61; k++) tick();
    model(61, 4, 4, 8, e, m);
    n_checks++;
    if ((obs_a & m) !== (e & m)) $display("[TB] FAIL done_state got=%h want=%h", obs_a & m, e & m);
    else n_pass++;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    model(0, 4, 4, 8, e, m);
    n_checks++;
    if (obs_a !== e) $display("[TB] FAIL start_in_done got=%h want=%h", obs_a, e);
    else n_pass++;
    tick();
    n_checks++;
    if (a_busy !== 1'b0) $display("[TB] FAIL start_in_done_busy got=%b want=0", a_busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_abort_vs_start();
    test_full_run_a();
    test_fd1_run_b();
    test_start_held();
    test_abort_mid_run();
    test_random_abort();
    test_reset_flush();
    test_start_in_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
